// File: rtl/mul_normalize.sv
// -----------------------------------------------------------------------------
// mul_normalize
//
// Post-processing stage for a 24x24 signed sequential multiplier. Takes the
// 48-bit two's-complement product and returns sign, a 24-bit normalized
// magnitude rounded to nearest-even, the normalization shift count and a
// rounding-overflow flag.
//
// Pipeline of states: IDLE -> ABS -> NORM (one shift per cycle) -> ROUND ->
// DONE -> IDLE. A zero product leaves NORM straight for DONE.
//
// Ports
//   clock_i        : single clock, all state changes on posedge
//   reset_ni       : asynchronous, active-low reset
//   start_i        : request, sampled only while idle
//   product_i      : 48-bit signed product, sampled on the accepting edge
//   mantissa_o     : 24-bit rounded normalized magnitude (bit 23 set unless 0)
//   sign_o         : sign of the captured product
//   lz_o           : left shifts applied during normalization (0..47)
//   round_carry_o  : rounding overflowed 24 bits; caller bumps its exponent
//   zero_o         : captured product was zero
//   busy_o         : high in ABS, NORM and ROUND
//   done_o         : one-cycle pulse, results valid from this cycle on
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mul_normalize (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [47:0] product_i,
  output logic [23:0] mantissa_o,
  output logic        sign_o,
  output logic [5:0]  lz_o,
  output logic        round_carry_o,
  output logic        zero_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  // Holds the raw product after capture, then the magnitude, then the
  // progressively left-shifted magnitude.
  logic [47:0] mag_q, mag_d;
  logic [23:0] mantissa_q, mantissa_d;
  logic        sign_q, sign_d;
  logic [5:0]  lz_q, lz_d;
  logic        round_carry_q, round_carry_d;
  logic        zero_q, zero_d;

  // Rounding terms, only meaningful in ROUND.
  logic        guard;
  logic        sticky;
  logic        lsb;
  logic        round_inc;
  logic [24:0] rounded;

  assign guard     = mag_q[23];
  assign sticky    = |mag_q[22:0];
  assign lsb       = mag_q[24];
  assign round_inc = guard & (sticky | lsb);
  // One bit wider than the mantissa so the rounding carry is never lost.
  assign rounded   = {1'b0, mag_q[47:24]} + {24'd0, round_inc};

  // NOTE: every signal assigned in this block gets its hold value first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    mantissa_d    = mantissa_q;
    sign_d        = sign_q;
    lz_d          = lz_q;
    round_carry_d = round_carry_q;
    zero_d        = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Results of the previous operation are released on acceptance.
          mag_d         = product_i;
          mantissa_d    = 24'd0;
          sign_d        = 1'b0;
          lz_d          = 6'd0;
          round_carry_d = 1'b0;
          zero_d        = 1'b0;
          state_d       = S_ABS;
        end
      end

      S_ABS: begin
        sign_d  = mag_q[47];
        // -2^47 negates to itself, which is exactly its unsigned magnitude.
        mag_d   = mag_q[47] ? (48'd0 - mag_q) : mag_q;
        lz_d    = 6'd0;
        state_d = S_NORM;
      end

      S_NORM: begin
        if (mag_q == 48'd0) begin
          // Zero is recognised on the registered magnitude, which places the
          // zero-result done pulse two edges after acceptance.
          zero_d        = 1'b1;
          mantissa_d    = 24'd0;
          lz_d          = 6'd0;
          round_carry_d = 1'b0;
          state_d       = S_DONE;
        end else if (mag_q[47]) begin
          state_d = S_ROUND;
        end else begin
          // A nonzero magnitude reaches bit 47 after at most 47 shifts, so
          // the 6-bit counter cannot wrap.
          mag_d = {mag_q[46:0], 1'b0};
          lz_d  = lz_q + 6'd1;
        end
      end

      S_ROUND: begin
        if (rounded[24]) begin
          // All-ones mantissa rounded up: renormalize to 1.000... and let the
          // caller account for the extra binade.
          mantissa_d    = 24'h800000;
          round_carry_d = 1'b1;
        end else begin
          mantissa_d    = rounded[23:0];
          round_carry_d = 1'b0;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      mag_q         <= 48'd0;
      mantissa_q    <= 24'd0;
      sign_q        <= 1'b0;
      lz_q          <= 6'd0;
      round_carry_q <= 1'b0;
      zero_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      mantissa_q    <= mantissa_d;
      sign_q        <= sign_d;
      lz_q          <= lz_d;
      round_carry_q <= round_carry_d;
      zero_q        <= zero_d;
    end
  end

  assign mantissa_o    = mantissa_q;
  assign sign_o        = sign_q;
  assign lz_o          = lz_q;
  assign round_carry_o = round_carry_q;
  assign zero_o        = zero_q;
  assign busy_o        = (state_q == S_ABS) || (state_q == S_NORM) || (state_q == S_ROUND);
  assign done_o        = (state_q == S_DONE);

endmodule
